// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch-stage program-counter generator with stall, halt, trap and jump redirects
// Optional build macro PC_MISALIGN_TRAP_EN turns misaligned redirect targets into traps.
module pc_gen_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0100,
  parameter int              INSN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] branch_dest,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_dest,
  input  logic            trap,
  input  logic            mret,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus,
  output logic [XLEN-1:0] epc,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign_err,
`endif
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } pc_state_t;

  localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

  pc_state_t       cur_state, nxt_state;
  logic [XLEN-1:0] pc_nxt, epc_nxt;
  logic [XLEN-1:0] tgt;
  logic            tgt_req;
`ifdef PC_MISALIGN_TRAP_EN
  logic            err_nxt;
`endif

  assign pc_plus  = pc + STEP;
  assign pc_valid = (cur_state == RUN);
  assign state    = cur_state;

  // Non-trap redirect target, already in priority order mret > jump > branch-taken.
  always_comb begin
    tgt     = '0;
    tgt_req = 1'b0;
    if (mret) begin
      tgt     = epc;
      tgt_req = 1'b1;
    end else if (jump) begin
      tgt     = jump_dest;
      tgt_req = 1'b1;
    end else if (branch && zero) begin
      tgt     = branch_dest;
      tgt_req = 1'b1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    pc_nxt    = pc;
    epc_nxt   = epc;
`ifdef PC_MISALIGN_TRAP_EN
    err_nxt   = 1'b0;
`endif
    case (cur_state)
      BOOT: nxt_state = RUN;
      RUN: begin
        if (trap) begin
          pc_nxt  = TRAP_VEC;
          epc_nxt = pc;
        end else if (tgt_req) begin
`ifdef PC_MISALIGN_TRAP_EN
          if ((tgt & ~ALIGN_MASK) != '0) begin
            pc_nxt  = TRAP_VEC;
            epc_nxt = tgt;
            err_nxt = 1'b1;
          end else begin
            pc_nxt  = tgt;
          end
`else
          pc_nxt = tgt & ALIGN_MASK;
`endif
        end else if (halt) begin
          nxt_state = HALT;
        end else if (fetch_ready) begin
          pc_nxt = pc_plus;
        end
      end
      HALT: begin
        // Only a trap may redirect out of halt; it also resumes execution.
        if (trap) begin
          pc_nxt    = TRAP_VEC;
          epc_nxt   = pc;
          nxt_state = RUN;
        end else if (resume) begin
          nxt_state = RUN;
        end
      end
      default: nxt_state = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= BOOT;
      pc        <= RESET_VEC;
      epc       <= '0;
    end else begin
      cur_state <= nxt_state;
      pc        <= pc_nxt;
      epc       <= epc_nxt;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_err <= 1'b0;
    else     misalign_err <= err_nxt;
  end
`endif

endmodule
